fir_mac_engine: RTL
===================

// Module: fir_mac_engine
// PURPOSE
//  Time-multiplexed multi-channel FIR MAC engine on one clock (clk1). Keeps a circular sample history
//  per channel and a shared coefficient table. Each accepted sample triggers a tap_len-cycle MAC pass
//  over that channel's history. The result is shifted and saturated to an output word.
//  Successor to the two-lane fixed 16-bit FIR lane: widths, depth and channel count are parametrised.
// PARAMETERS
//  DW        16   sample and output width, signed
//  CW        16   coefficient width, signed
//  AW        8    log2 of history depth; MAX_TAPS = 2**AW
//  NCH       2    channel count, >=1; CHW = max(1,clog2(NCH))
//  ACW       40   accumulator width; must be >= DW+CW+AW, so the accumulator never overflows
// PORTS
//  clk1       in   1      clock
//  rst        in   1      synchronous reset, active high
//  in_valid   in   1      sample offered
//  in_ready   out  1      engine can accept a sample (IDLE only)
//  in_ch      in   CHW    channel of the offered sample
//  in_data    in   DW     signed sample
//  tap_len    in   AW+1   taps to use, 1..MAX_TAPS; 0 is treated as 1; sampled on accept
//  out_shift  in   6      arithmetic right shift applied to acc; sampled on accept
//  coef_wr    in   1      coefficient write strobe (any cycle)
//  coef_addr  in   AW     coefficient index k
//  coef_data  in   CW     signed coefficient
//  out_valid  out  1      one-cycle result strobe
//  out_ch     out  CHW    channel of the result
//  out_data   out  DW     saturated result; held until the next out_valid
//  out_sat    out  1      saturation occurred on this result; valid with out_valid
// BEHAVIOUR
//  Reset values: in_ready=0, out_valid=0, out_ch=0, out_data=0, out_sat=0; all write pointers=0;
//  state=INIT. Reset aborts any pass immediately; no out_valid is issued for an aborted pass.
//  FSM:
//   INIT:  writes 0 to every history word, one word per cycle, NCH*MAX_TAPS cycles. Then -> IDLE.
//   IDLE:  in_ready=1. On in_valid:
//          - writes in_data to hist[in_ch][wptr[in_ch]];
//          - latches ch, L=max(tap_len,1) and shift;
//          - goes to MAC. Call this accept cycle T.
//   MAC:   cycles T+1..T+L, with k=0..L-1. Reads hist[ch][(wptr[ch]-k) mod MAX_TAPS] and coef[k].
//          The address wraps modulo MAX_TAPS. After the last issue -> DRAIN.
//   DRAIN: 3 cycles (read register, multiply register, accumulate). Then IDLE, with out_valid=1 at T+L+4.
//   The accept cycle also increments wptr[ch]. The MAC reads therefore use the pre-increment pointer,
//   so k=0 is the new sample.
//  Throughput: one sample per L+4 cycles. in_ready is high again in the out_valid cycle, so a
//   back-to-back accept is allowed in that cycle.
//  in_ch >= NCH: the sample is accepted and discarded. No history write, no pass, no out_valid.
//  Arithmetic:
//   - product: signed DW x CW -> DW+CW bits, sign-extended to ACW;
//   - acc: cleared on accept, sums the L products;
//   - r = acc >>> shift (arithmetic).
//   - if r > 2**(DW-1)-1: out_data = 0x7FF..F, out_sat=1;
//     if r < -2**(DW-1):  out_data = 0x800..0, out_sat=1;
//     else:               out_data = r[DW-1:0], out_sat=0.
//  Coefficient writes are accepted in any state and are written in the same cycle. A read and write of
//   the same index in the same cycle returns the old value. The next cycle returns the new value.
//  History is per channel. Channels never observe each other's samples.
// TESTING
//  1 rst high 2 cycles, then low: in_ready=0 for exactly NCH*MAX_TAPS cycles, then 1.
//    All outputs 0 during this time.
//  2 coef[0..3]=1,2,3,4; L=4; shift=0; ch0 samples 1,0,0,0,0:
//    out_data = 1,2,3,4,0; each out_valid exactly 8 cycles after its accept.
//  3 Same coefficients; ch0 impulse, then ch1 samples 5,5. ch1 out = 5,15; ch0 history is unaffected.
//  4 coef[0]=0x7FFF; L=1; sample 0x7FFF; shift=0: out_data=0x7FFF, out_sat=1.
//    Repeat with shift=15: out_data=0x7FFE, out_sat=0.
//  5 L=MAX_TAPS, all coefs 1; feed MAX_TAPS+3 samples of value 1: the pointer wraps.
//    Outputs ramp 1..MAX_TAPS, then hold at MAX_TAPS.
//  6 rst asserted at T+2 of a pass: no out_valid; INIT reruns. The next pass sees zeroed history.

Source files
------------

// File: rtl/fir_mac_engine.sv
// Time-multiplexed multi-channel FIR MAC engine: per-channel circular sample history,
// shared coefficient table, one tap per cycle, shifted and saturated result per accepted sample.
module fir_mac_engine #(
  parameter int DW  = 16,
  parameter int CW  = 16,
  parameter int AW  = 8,
  parameter int NCH = 2,
  parameter int ACW = 40,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CHW-1:0]        in_ch,
  input  logic signed [DW-1:0]  in_data,
  input  logic [AW:0]           tap_len,
  input  logic [5:0]            out_shift,
  input  logic                  coef_wr,
  input  logic [AW-1:0]         coef_addr,
  input  logic signed [CW-1:0]  coef_data,
  output logic                  out_valid,
  output logic [CHW-1:0]        out_ch,
  output logic signed [DW-1:0]  out_data,
  output logic                  out_sat
);

  localparam int MAX_TAPS = 2 ** AW;
  localparam int HW       = CHW + AW;
  localparam int NW       = NCH * MAX_TAPS;
  localparam int PW       = DW + CW;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]              state;
  logic signed [DW-1:0]    hist [NW];
  logic signed [CW-1:0]    coef [MAX_TAPS];
  logic [AW-1:0]           wptr [NCH];
  logic [HW-1:0]           init_cnt;
  logic [CHW-1:0]          ch;
  logic [AW-1:0]           base;
  logic [AW-1:0]           k;
  logic [AW-1:0]           last_k;
  logic [5:0]              shift;
  logic [1:0]              drain_cnt;
  logic                    rd_v;
  logic                    p_v;
  logic signed [DW-1:0]    rd_hist;
  logic signed [CW-1:0]    rd_coef;
  logic signed [PW-1:0]    prod;
  logic signed [ACW-1:0]   acc;

  logic                    ch_ok;
  logic                    accept;
  logic                    hist_we;
  logic [HW-1:0]           hist_wa;
  logic signed [DW-1:0]    hist_wd;
  logic [AW-1:0]           rd_off;
  logic [HW-1:0]           rd_addr;
  logic signed [ACW-1:0]   r;
  logic [ACW-DW:0]         r_hi;
  logic signed [DW-1:0]    sat_data;
  logic                    sat_flag;

  assign in_ready = (state == S_IDLE);
  assign ch_ok    = (32'(in_ch) < NCH);
  assign accept   = in_ready && in_valid;
  assign rd_off   = base - k;
  assign rd_addr  = {ch, rd_off};

  always_comb begin
    hist_we = 1'b0;
    hist_wa = '0;
    hist_wd = '0;
    if (!rst) begin
      if (state == S_INIT) begin
        hist_we = 1'b1;
        hist_wa = init_cnt;
      end else if (accept && ch_ok) begin
        hist_we = 1'b1;
        hist_wa = {in_ch, wptr[in_ch]};
        hist_wd = in_data;
      end
    end
  end

  // Saturate when the bits above the output sign bit are not a pure sign extension.
  always_comb begin
    r        = acc >>> shift;
    r_hi     = r[ACW-1:DW-1];
    sat_flag = 1'b0;
    sat_data = r[DW-1:0];
    if (!(r_hi == '0 || r_hi == '1)) begin
      sat_flag = 1'b1;
      sat_data = r[ACW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  // Storage and datapath pipeline; reads register the pre-write contents.
  always_ff @(posedge clk1) begin
    if (hist_we) hist[hist_wa] <= hist_wd;
    if (coef_wr) coef[coef_addr] <= coef_data;
    rd_hist <= hist[rd_addr];
    rd_coef <= coef[k];
    prod    <= PW'(rd_hist) * PW'(rd_coef);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      for (int unsigned i = 0; i < NCH; i++) wptr[i] <= '0;
      ch        <= '0;
      base      <= '0;
      k         <= '0;
      last_k    <= '0;
      shift     <= '0;
      drain_cnt <= '0;
      rd_v      <= 1'b0;
      p_v       <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      rd_v      <= (state == S_MAC);
      p_v       <= rd_v;
      if (p_v) acc <= acc + {{(ACW-PW){prod[PW-1]}}, prod};
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == HW'(NW - 1)) state <= S_IDLE;
        end
        S_IDLE: begin
          if (accept && ch_ok) begin
            wptr[in_ch] <= wptr[in_ch] + 1'b1;
            ch          <= in_ch;
            base        <= wptr[in_ch];
            k           <= '0;
            last_k      <= (tap_len == '0) ? '0 : AW'(tap_len - 1'b1);
            shift       <= out_shift;
            acc         <= '0;
            state       <= S_MAC;
          end
        end
        S_MAC: begin
          k <= k + 1'b1;
          if (k == last_k) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        default: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 2'd2) begin
            state     <= S_IDLE;
            out_valid <= 1'b1;
            out_ch    <= ch;
            out_data  <= sat_data;
            out_sat   <= sat_flag;
          end
        end
      endcase
    end
  end

endmodule
